// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the instruction-cache scramble
// key manager.
//   - scr_key_st_e     : key manager FSM state encoding
//   - SCRAMBLE_KEY_W   : default scramble key width
//   - SCRAMBLE_NONCE_W : default tag nonce width
//   - RNDCNST_SCR_*    : key/nonce used from reset until the first rekey
package ibex_pkg;

  localparam int unsigned SCRAMBLE_KEY_W   = 128;
  localparam int unsigned SCRAMBLE_NONCE_W = 64;

  localparam logic [SCRAMBLE_KEY_W-1:0]   RNDCNST_SCR_KEY =
      128'h14e8cecae3040d5e12286bb3cc113298;
  localparam logic [SCRAMBLE_NONCE_W-1:0] RNDCNST_SCR_NONCE =
      64'hf79780bc735f3843;

  typedef enum logic [1:0] {
    ScrIdle     = 2'd0,
    ScrReq      = 2'd1,
    ScrInval    = 2'd2,
    ScrWaitBusy = 2'd3
  } scr_key_st_e;

endpackage

// File: rtl/ibex_icache_scr_key_mgr.sv
// ibex_icache_scr_key_mgr: fetches a new scramble key/nonce from a key
// source on request, invalidates the instruction cache and reports
// completion or timeout.
//
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   rekey_req_i        core request for a new key (level or pulse)
//   key_req_o          request to the key source
//   key_ack_i          key source ack; key_i / nonce_i valid this cycle
//   key_i, nonce_i     new key and nonce
//   key_valid_o        key/nonce outputs usable by the RAMs
//   key_o              current key
//   tag_nonce_o        current nonce
//   data_nonce_o       {previous, current} nonce, or current nonce only
//   icache_inval_o     one-cycle invalidate pulse to the cache
//   icache_busy_i      cache invalidation in progress
//   rekey_done_o       one-cycle completion pulse
//   rekey_err_o        one-cycle key source timeout pulse
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ScrIdle     | old or new key in use, waiting for a rekey request
// ScrReq      | key requested, waiting for ack; key outputs not valid
// ScrInval    | new key captured, invalidate pulse to the cache
// ScrWaitBusy | waiting for the cache to finish invalidating
module ibex_icache_scr_key_mgr
  import ibex_pkg::*;
#(
  parameter int unsigned KeyW          = SCRAMBLE_KEY_W,
  parameter int unsigned NonceW        = SCRAMBLE_NONCE_W,
  parameter int unsigned DataNonceW    = 2 * SCRAMBLE_NONCE_W,
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [KeyW-1:0]   RndCnstKey   = KeyW'(RNDCNST_SCR_KEY),
  parameter logic [NonceW-1:0] RndCnstNonce = NonceW'(RNDCNST_SCR_NONCE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rekey_req_i,
  output logic                  key_req_o,
  input  logic                  key_ack_i,
  input  logic [KeyW-1:0]       key_i,
  input  logic [NonceW-1:0]     nonce_i,
  output logic                  key_valid_o,
  output logic [KeyW-1:0]       key_o,
  output logic [NonceW-1:0]     tag_nonce_o,
  output logic [DataNonceW-1:0] data_nonce_o,
  output logic                  icache_inval_o,
  input  logic                  icache_busy_i,
  output logic                  rekey_done_o,
  output logic                  rekey_err_o
);

  if (!(DataNonceW == NonceW || DataNonceW == 2 * NonceW)) begin : g_bad_data_nonce_w
    $error("DataNonceW must be NonceW or 2*NonceW");
  end
  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_bad_timeout
    $error("TimeoutCycles must be in 2..65535");
  end

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  scr_key_st_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              pending_q;
  logic [KeyW-1:0]   key_q;
  logic [NonceW-1:0] nonce_q;
  logic              capture;
  logic              req_entry;

  always_comb begin
    state_d        = state_q;
    key_req_o      = 1'b0;
    icache_inval_o = 1'b0;
    rekey_done_o   = 1'b0;
    rekey_err_o    = 1'b0;
    capture        = 1'b0;
    req_entry      = 1'b0;
    unique case (state_q)
      ScrIdle: begin
        if (rekey_req_i || pending_q) begin
          state_d   = ScrReq;
          req_entry = 1'b1;
        end
      end
      ScrReq: begin
        key_req_o = 1'b1;
        // An ack in the last allowed cycle still wins over the timeout.
        if (key_ack_i) begin
          capture = 1'b1;
          state_d = ScrInval;
        end else if (cnt_q == CntLast) begin
          rekey_err_o = 1'b1;
          state_d     = ScrIdle;
        end
      end
      ScrInval: begin
        icache_inval_o = 1'b1;
        state_d        = ScrWaitBusy;
      end
      ScrWaitBusy: begin
        if (!icache_busy_i) begin
          rekey_done_o = 1'b1;
          state_d      = ScrIdle;
        end
      end
      default: state_d = ScrIdle;
    endcase
  end

  assign key_valid_o = (state_q != ScrReq);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ScrIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_entry) begin
        cnt_q <= '0;
      end else if (state_q == ScrReq) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // Requests arriving mid-rekey collapse into a single follow-up rekey.
      if (rekey_req_i && state_q != ScrIdle) begin
        pending_q <= 1'b1;
      end else if (req_entry) begin
        pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q   <= RndCnstKey;
      nonce_q <= RndCnstNonce;
    end else if (capture) begin
      key_q   <= key_i;
      nonce_q <= nonce_i;
    end
  end

  assign key_o       = key_q;
  assign tag_nonce_o = nonce_q;

  if (DataNonceW == 2 * NonceW) begin : g_dual_nonce
    logic [NonceW-1:0] nonce_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        nonce_prev_q <= RndCnstNonce;
      end else if (capture) begin
        nonce_prev_q <= nonce_q;
      end
    end

    assign data_nonce_o = {nonce_prev_q, nonce_q};
  end else begin : g_single_nonce
    assign data_nonce_o = nonce_q;
  end

endmodule

// File: tb/tb_ibex_icache_scr_key_mgr.sv
// Testbench for ibex_icache_scr_key_mgr. The stimulus driver issues rekey
// transactions with random ack delay, busy length, gaps and merged requests,
// and pushes the expected inval/done/err events (cycle plus key state) into
// a queue; a negedge monitor pops and compares whenever the DUT pulses one.
module tb_ibex_icache_scr_key_mgr;

  localparam int T = 8;
  localparam logic [127:0] RK = 128'h14e8cecae3040d5e12286bb3cc113298;
  localparam logic [63:0]  RN = 64'hf79780bc735f3843;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         rekey_req_i;
  logic         key_req_o;
  logic         key_ack_i;
  logic [127:0] key_i;
  logic [63:0]  nonce_i;
  logic         key_valid_o;
  logic [127:0] key_o;
  logic [63:0]  tag_nonce_o;
  logic [127:0] data_nonce_o;
  logic         icache_inval_o;
  logic         icache_busy_i;
  logic         rekey_done_o;
  logic         rekey_err_o;

  ibex_icache_scr_key_mgr #(
    .KeyW         (128),
    .NonceW       (64),
    .DataNonceW   (128),
    .TimeoutCycles(T)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rekey_req_i   (rekey_req_i),
    .key_req_o     (key_req_o),
    .key_ack_i     (key_ack_i),
    .key_i         (key_i),
    .nonce_i       (nonce_i),
    .key_valid_o   (key_valid_o),
    .key_o         (key_o),
    .tag_nonce_o   (tag_nonce_o),
    .data_nonce_o  (data_nonce_o),
    .icache_inval_o(icache_inval_o),
    .icache_busy_i (icache_busy_i),
    .rekey_done_o  (rekey_done_o),
    .rekey_err_o   (rekey_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           kind;  // 0 inval, 1 done, 2 err
    int           cyc;
    logic [127:0] key;
    logic [63:0]  nonce;
    logic [127:0] dn;
    logic         kv;
    logic         kr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: key in use, current nonce, nonce before the last capture.
  logic [127:0] m_key;
  logic [63:0]  m_cur, m_prev;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind, input int c, input logic kv, input logic kr);
    exp_t e;
    e.kind  = kind;
    e.cyc   = c;
    e.key   = m_key;
    e.nonce = m_cur;
    e.dn    = {m_prev, m_cur};
    e.kv    = kv;
    e.kr    = kr;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk_i) begin
    int   k;
    exp_t e;
    if (rst_ni === 1'b1 && (icache_inval_o || rekey_done_o || rekey_err_o)) begin
      k = rekey_err_o ? 2 : (rekey_done_o ? 1 : 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 128'(k), 128'(e.kind));
        chk("event_cycle", 128'(cyc), 128'(e.cyc));
        chk("key_o", key_o, e.key);
        chk("tag_nonce_o", 128'(tag_nonce_o), 128'(e.nonce));
        chk("data_nonce_o", data_nonce_o, e.dn);
        chk("key_valid_o", 128'(key_valid_o), 128'(e.kv));
        chk("key_req_o", 128'(key_req_o), 128'(e.kr));
      end
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // t0: cycle in which the request is seen in IDLE (or pending already set)
  // d : REQ cycle index carrying the ack (>= T means no ack, timeout)
  // b : cycles busy stays high in WAIT_BUSY
  // pend: raise a merged double request during WAIT_BUSY
  // g : idle gap cycles before the next request (a stray ack is sent in it)
  task automatic do_rekey(input int t0, input int d, input int b, input bit pend,
                          input bit already, input int g, output int tnext);
    logic [127:0] nk;
    logic [63:0]  nn;
    int           ev_end;
    if (!already) begin
      at_cycle(t0);
      rekey_req_i = 1'b1;
    end
    at_cycle(t0 + 1);
    rekey_req_i = 1'b0;
    key_i   = rnd128();
    nonce_i = 64'(rnd128());
    if (d < T) begin
      nk = rnd128();
      nn = 64'(rnd128());
      m_prev = m_cur;
      m_cur  = nn;
      m_key  = nk;
      push_ev(0, t0 + 2 + d, 1'b1, 1'b0);
      push_ev(1, t0 + 3 + d + b, 1'b1, 1'b0);
      at_cycle(t0 + 1 + d);
      key_ack_i = 1'b1;
      key_i     = nk;
      nonce_i   = nn;
      at_cycle(t0 + 2 + d);
      key_ack_i = 1'b0;
      key_i     = rnd128();
      nonce_i   = 64'(rnd128());
      if (b > 0) icache_busy_i = 1'b1;
      if (pend) begin
        at_cycle(t0 + 3 + d);
        rekey_req_i = 1'b1;
        at_cycle(t0 + 4 + d);
        rekey_req_i = 1'b0;
      end
      ev_end = t0 + 3 + d + b;
      at_cycle(ev_end);
      icache_busy_i = 1'b0;
    end else begin
      push_ev(2, t0 + T, 1'b0, 1'b1);
      ev_end = t0 + T;
    end
    if (pend) begin
      tnext = ev_end + 1;
    end else begin
      tnext = ev_end + 1 + g;
      if (g > 0) begin
        at_cycle(ev_end + 1);
        key_ack_i = 1'b1;
        key_i     = rnd128();
        nonce_i   = 64'(rnd128());
        at_cycle(ev_end + 2);
        key_ack_i = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d events outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int  t, tn, d, b, g;
    bit  pend, already;
    rst_ni        = 1'b0;
    rekey_req_i   = 1'b0;
    key_ack_i     = 1'b0;
    key_i         = '0;
    nonce_i       = '0;
    icache_busy_i = 1'b0;
    m_key  = RK;
    m_cur  = RN;
    m_prev = RN;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_key_o", key_o, RK);
    chk("rst_tag_nonce_o", 128'(tag_nonce_o), 128'(RN));
    chk("rst_data_nonce_o", data_nonce_o, {RN, RN});
    chk("rst_key_valid_o", 128'(key_valid_o), 128'(1));
    chk("rst_pulses", 128'({key_req_o, icache_inval_o, rekey_done_o, rekey_err_o}), 128'(0));
    rst_ni = 1'b1;
    t = cyc + 1;

    do_rekey(t, 0, 0, 1'b0, 1'b0, 1, tn);     t = tn;  // minimum latency
    do_rekey(t, 0, 10, 1'b0, 1'b0, 2, tn);    t = tn;  // long busy
    do_rekey(t, T, 0, 1'b0, 1'b0, 1, tn);     t = tn;  // timeout
    do_rekey(t, T - 1, 0, 1'b0, 1'b0, 0, tn); t = tn;  // ack in timeout cycle
    do_rekey(t, 0, 3, 1'b1, 1'b0, 0, tn);     t = tn;  // merged request in WAIT_BUSY
    do_rekey(t, 0, 0, 1'b0, 1'b1, 1, tn);     t = tn;

    already = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d    = $urandom_range(0, T + 1);
      b    = $urandom_range(0, 4);
      g    = $urandom_range(0, 3);
      pend = (d < T) && (b >= 1) && ($urandom_range(0, 3) == 0);
      do_rekey(t, d, b, pend, already, g, tn);
      already = pend;
      t = tn;
    end
    if (already) begin
      do_rekey(t, 0, 0, 1'b0, 1'b1, 1, tn);
      t = tn;
    end

    // Reset in the middle of REQ: no pulses, reset key/nonce back in use.
    at_cycle(t);
    rekey_req_i = 1'b1;
    at_cycle(t + 1);
    rekey_req_i = 1'b0;
    at_cycle(t + 3);
    rst_ni = 1'b0;
    #1;
    chk("midrst_key_o", key_o, RK);
    chk("midrst_key_req_o", 128'(key_req_o), 128'(0));
    chk("midrst_key_valid_o", 128'(key_valid_o), 128'(1));
    chk("midrst_data_nonce_o", data_nonce_o, {RN, RN});
    key_ack_i = 1'b1;
    key_i     = rnd128();
    nonce_i   = 64'(rnd128());
    at_cycle(t + 4);
    rst_ni    = 1'b1;
    key_ack_i = 1'b0;
    m_key  = RK;
    m_cur  = RN;
    m_prev = RN;
    at_cycle(t + 8);
    chk("postrst_key_o", key_o, RK);
    chk("postrst_key_valid_o", 128'(key_valid_o), 128'(1));
    do_rekey(t + 9, 1, 1, 1'b0, 1'b0, 1, tn);
    t = tn;

    at_cycle(t + 4);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_icache_scr_key_mgr.md
IBEX_ICACHE_SCR_KEY_MGR -- requirements
Module: ibex_icache_scr_key_mgr

Interface
REQ-001 Parameter KeyW, default 128, scramble key width.
REQ-002 Parameter NonceW, default 64, tag nonce width.
REQ-003 Parameter DataNonceW, default 128, data nonce width; legal values NonceW or 2*NonceW.
REQ-004 Parameter TimeoutCycles, default 1024, maximum REQ-state wait for key_ack_i; range 2..65535.
REQ-005 Parameter RndCnstKey / RndCnstNonce, defaults 128'h14e8cecae3040d5e12286bb3cc113298 / 64'hf79780bc735f3843, reset key and nonce.
REQ-006 Reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_ni  in  1  async active-low reset.
REQ-009 rekey_req_i  in  1  core request for a new key (level or pulse).
REQ-010 key_req_o  out  1  request to key source.
REQ-011 key_ack_i  in  1  key source acknowledge; key_i and nonce_i valid this cycle.
REQ-012 key_i  in  KeyW  new key; nonce_i  in  NonceW  new nonce.
REQ-013 key_valid_o  out  1  key/nonce outputs usable by RAMs.
REQ-014 key_o  out  KeyW; tag_nonce_o  out  NonceW; data_nonce_o  out  DataNonceW.
REQ-015 icache_inval_o  out  1  single-cycle invalidate pulse to cache.
REQ-016 icache_busy_i  in  1  cache invalidation in progress.
REQ-017 rekey_done_o  out  1  single-cycle completion pulse; rekey_err_o  out  1  single-cycle timeout pulse.

Function
REQ-018 FSM states IDLE, REQ, INVAL, WAIT_BUSY; reset state IDLE.
REQ-019 IDLE: on rekey_req_i or pending flag set, go to REQ and clear pending.
REQ-020 REQ: key_req_o=1, key_valid_o=0; on key_ack_i capture key_i/nonce_i same edge, go to INVAL.
REQ-021 REQ timeout: counter clears on REQ entry; if count reaches TimeoutCycles-1 without ack, pulse rekey_err_o, keep old key/nonce, restore key_valid_o=1, go to IDLE.
REQ-022 Ack in the timeout cycle takes priority over timeout.
REQ-023 INVAL: icache_inval_o=1 for exactly one cycle, key_valid_o=1 with new key, go to WAIT_BUSY.
REQ-024 WAIT_BUSY: stay while icache_busy_i=1; first cycle with icache_busy_i=0 (earliest cycle after INVAL) pulse rekey_done_o, go to IDLE.
REQ-025 Minimum rekey latency: rekey_req_i to rekey_done_o = 3 cycles with ack in first REQ cycle and busy low.
REQ-026 rekey_req_i outside IDLE sets one-deep pending flag; further requests merge.
REQ-027 key_ack_i outside REQ ignored, no state change.
REQ-028 tag_nonce_o = current nonce.
REQ-029 DataNonceW==2*NonceW: data_nonce_o = {previous nonce, current nonce}, previous nonce = value held before last capture.
REQ-030 DataNonceW==NonceW: data_nonce_o = current nonce.
REQ-031 Illegal DataNonceW or TimeoutCycles: elaboration-time assertion failure.

Reset
REQ-032 Reset values: key_o=RndCnstKey, tag_nonce_o=RndCnstNonce, data_nonce_o={RndCnstNonce,RndCnstNonce} (or RndCnstNonce), key_valid_o=1, all other outputs 0, pending=0, counter=0.
REQ-033 Reset mid-rekey: immediate return to reset values; captured key discarded; no done/err pulse.

Structure
REQ-034 State enum, reset key/nonce constants and SCRAMBLE_KEY_W/SCRAMBLE_NONCE_W defaults belong in ibex_pkg.
REQ-035 Single module; no sub-modules; timeout counter width $clog2(TimeoutCycles).

Verification
REQ-036 Rekey, ack first REQ cycle, busy low -> key_o=key_i, data_nonce_o={RndCnstNonce,nonce_i}, inval pulse cycle 2, done cycle 3.
REQ-037 Ack, busy held high 10 cycles -> done exactly 1 cycle after busy falls; inval single pulse.
REQ-038 No ack, TimeoutCycles=8 -> err pulse 8 cycles after REQ entry, key_o unchanged, key_valid_o=1.
REQ-039 Second rekey_req_i during WAIT_BUSY -> second REQ entered cycle after done; two captures; data_nonce_o={nonce1,nonce2}.
REQ-040 rst_ni low during REQ -> key_o=RndCnstKey, key_req_o=0, no done/err; ack outside REQ -> no change.
